// File: rtl/mux_arb_nx1.sv
// mux_arb_nx1 -- parametrised N:1 stream multiplexer with a registered output.
// Selection is either a fixed channel index (mode=0) or round-robin
// arbitration (mode=1). Every input and the output use a valid/ready handshake.
// Optional packet lock: define MUX_ARB_LOCK_EN to add din_last_i/dout_last_o
// and keep a round-robin grant on one channel until its last beat.
module mux_arb_nx1 #(
    parameter  int CH = 4,
    parameter  int DW = 8,
    localparam int SW = $clog2(CH)
) (
    input  logic [0:0]       clk_i,
    input  logic [0:0]       rst_n_i,
    input  logic [CH*DW-1:0] din_i,
    input  logic [CH-1:0]    din_vld_i,
    output logic [CH-1:0]    din_rdy_o,
`ifdef MUX_ARB_LOCK_EN
    input  logic [CH-1:0]    din_last_i,
    output logic [0:0]       dout_last_o,
`endif
    input  logic [0:0]       mode_i,
    input  logic [SW-1:0]    sel_i,
    output logic [DW-1:0]    dout_o,
    output logic [SW-1:0]    dout_ch_o,
    output logic [0:0]       dout_vld_o,
    input  logic [0:0]       dout_rdy_i
);

`ifdef MUX_ARB_LOCK_EN
    typedef enum logic {
        LOCK_IDLE,
        LOCK_HELD
    } lock_e;

    lock_e         lock_q, lock_d;
    logic [SW-1:0] lock_ch_q, lock_ch_d;
    logic          dout_last_q, dout_last_d;
    logic          beat_last;
`endif

    logic [DW-1:0] dout_q, dout_d;
    logic [SW-1:0] dout_ch_q, dout_ch_d;
    logic          dout_vld_q, dout_vld_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic [SW-1:0] rr_grant;
    logic          rr_found;
    logic          fix_vld;
    logic [SW-1:0] grant;
    logic          cand_vld;
    logic          load;
    logic          advance;
    logic [DW-1:0] grant_data;

    // Round-robin scan: first valid channel at or above ptr, else wrap to the lowest one below ptr.
    always_comb begin
        rr_grant = '0;
        rr_found = 1'b0;
        for (int c = 0; c < CH; c++) begin
            if (!rr_found && din_vld_i[c] && (SW'(c) >= ptr_q)) begin
                rr_grant = SW'(c);
                rr_found = 1'b1;
            end
        end
        for (int c = 0; c < CH; c++) begin
            if (!rr_found && din_vld_i[c] && (SW'(c) < ptr_q)) begin
                rr_grant = SW'(c);
                rr_found = 1'b1;
            end
        end
    end

    // Fixed-select candidate; an index past the last channel matches nothing and so never loads.
    always_comb begin
        fix_vld = 1'b0;
        for (int c = 0; c < CH; c++) begin
            if (sel_i == SW'(c)) begin
                fix_vld = din_vld_i[c];
            end
        end
    end

    // Pick the granted channel; a held packet lock overrides the round-robin scan.
    always_comb begin
        grant    = sel_i;
        cand_vld = fix_vld;
        if (mode_i) begin
            grant    = rr_grant;
            cand_vld = rr_found;
`ifdef MUX_ARB_LOCK_EN
            if (lock_q == LOCK_HELD) begin
                grant    = lock_ch_q;
                cand_vld = 1'b0;
                for (int c = 0; c < CH; c++) begin
                    if (lock_ch_q == SW'(c)) begin
                        cand_vld = din_vld_i[c];
                    end
                end
            end
`endif
        end
    end

    // Accept a beat when the output register is free or draining; nothing is ready during reset.
    always_comb begin
        load       = rst_n_i & (~dout_vld_q | dout_rdy_i) & cand_vld;
        din_rdy_o  = '0;
        grant_data = '0;
        for (int c = 0; c < CH; c++) begin
            din_rdy_o[c] = load & (grant == SW'(c));
            if (grant == SW'(c)) begin
                grant_data = din_i[c*DW +: DW];
            end
        end
    end

    // Next state of the output register, the round-robin pointer and the packet lock.
    always_comb begin
        dout_d     = dout_q;
        dout_ch_d  = dout_ch_q;
        dout_vld_d = dout_vld_q;
        ptr_d      = ptr_q;
        advance    = 1'b1;
`ifdef MUX_ARB_LOCK_EN
        lock_d      = lock_q;
        lock_ch_d   = lock_ch_q;
        dout_last_d = dout_last_q;
        beat_last   = 1'b0;
        for (int c = 0; c < CH; c++) begin
            if (grant == SW'(c)) begin
                beat_last = din_last_i[c];
            end
        end
        advance = beat_last;
        if (!mode_i) begin
            lock_d = LOCK_IDLE;
        end else if (load) begin
            lock_d    = beat_last ? LOCK_IDLE : LOCK_HELD;
            lock_ch_d = grant;
        end
        if (load) begin
            dout_last_d = beat_last;
        end
`endif
        if (load) begin
            dout_d     = grant_data;
            dout_ch_d  = grant;
            dout_vld_d = 1'b1;
        end else if (dout_rdy_i) begin
            dout_vld_d = 1'b0;
        end
        if (mode_i && load && advance) begin
            ptr_d = (grant == SW'(CH - 1)) ? '0 : grant + SW'(1);
        end
    end

    // State registers with synchronous active-low reset; reset drops any held beat.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            dout_q     <= '0;
            dout_ch_q  <= '0;
            dout_vld_q <= 1'b0;
            ptr_q      <= '0;
`ifdef MUX_ARB_LOCK_EN
            lock_q      <= LOCK_IDLE;
            lock_ch_q   <= '0;
            dout_last_q <= 1'b0;
`endif
        end else begin
            dout_q     <= dout_d;
            dout_ch_q  <= dout_ch_d;
            dout_vld_q <= dout_vld_d;
            ptr_q      <= ptr_d;
`ifdef MUX_ARB_LOCK_EN
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
            dout_last_q <= dout_last_d;
`endif
        end
    end

    assign dout_o     = dout_q;
    assign dout_ch_o  = dout_ch_q;
    assign dout_vld_o = dout_vld_q;
`ifdef MUX_ARB_LOCK_EN
    assign dout_last_o = dout_last_q;
`endif

endmodule
